cpu_bus_responder: RTL and testbench
====================================

Name: cpu_bus_responder

Overview:
- Device-side end of the 6502 external address/data bus. It answers the access that the CPU address-bus registers (high and low bytes) and the data-output latch present.
- Decodes the 16-bit CPU address into three targets: 2 KB internal work RAM (mirrored), PPU register window (mirrored), and cartridge space.
- Serves RAM accesses locally. Forwards PPU and cartridge accesses over a req/ack handshake with a timeout.
- Returns read data, or open-bus data, to the CPU data-input latch with a one-cycle ready pulse.

Parameters:
- RAM_ADDR_W, 11, work RAM address width (2 KB).
- TIMEOUT_CYC, 15, cycles to wait for dev_ack_IN before aborting; legal range 1–255.

Ports:
- phi2  input  1  bus clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- access_EN  input  1  start-access strobe, sampled only in IDLE.
- rw_IN  input  1  1 = read, 0 = write.
- address_IN  input  16  CPU address (ABH:ABL).
- data_IN  input  8  CPU write data.
- data_OUT  output  8  read data / open-bus value to CPU.
- ready_OUT  output  1  one-cycle completion pulse.
- busy_OUT  output  1  high in every non-IDLE state.
- timeout_OUT  output  1  one-cycle pulse, coincident with ready_OUT, on aborted device access.
- dev_sel_OUT  output  2  0 = none, 1 = PPU, 2 = cartridge.
- dev_req_OUT  output  1  device request, level.
- dev_addr_OUT  output  16  device address.
- dev_rw_OUT  output  1  device direction.
- dev_wdata_OUT  output  8  device write data.
- dev_rdata_IN  input  8  device read data, valid with ack.
- dev_ack_IN  input  1  device acknowledge.

Behaviour:
- Decode (address_IN at access_EN):
  - $0000–$1FFF → RAM, index addr[10:0].
  - $2000–$3FFF → PPU; dev_addr_OUT = {13'h0400, addr[2:0]}, i.e. $2000 + addr[2:0].
  - $4000–$401F → unmapped (CPU-internal APU/IO).
  - $4020–$FFFF → cartridge; dev_addr_OUT = addr unchanged.
- State machine:
  - IDLE: on access_EN, register address, rw and wdata, and go to the region state. Otherwise stay.
  - RAM_ACC: a write commits to RAM at the end of this cycle; a read issues the synchronous RAM read → DONE.
  - DEV_WAIT: dev_req_OUT = 1, with sel/addr/rw/wdata stable. On dev_ack_IN sampled high, capture dev_rdata_IN (reads) → DONE. The timeout counter loads 0 on entry and increments each cycle without ack. When it reaches TIMEOUT_CYC-1 with no ack → DONE with the abort flag set.
  - UNMAP: → DONE.
  - DONE: ready_OUT = 1 for this cycle; timeout_OUT = abort flag → IDLE.
- Latency from access_EN sampled to ready_OUT high:
  - RAM and unmapped: 2 cycles.
  - Device: ack-sample cycle + 1.
  - Timeout: TIMEOUT_CYC + 1.
- Open-bus latch, 8 bit:
  - Updated in DONE with the read data (successful reads) or data_IN (writes, any region).
  - Unchanged on unmapped or aborted reads.
  - data_OUT always equals the latch; the DONE value is valid while ready_OUT is high.
- Boundary conditions:
  - access_EN while busy: ignored, no queuing.
  - dev_ack_IN outside DEV_WAIT (late or spurious): ignored.
  - Ack in the same cycle the timeout would fire: ack wins.
  - dev_req_OUT drops the cycle after the ack is sampled.
- Reset:
  - All outputs 0 and state IDLE, applied at the next edge with reset high.
  - Applies mid-operation: dev_req_OUT falls, and no ready or timeout pulse is produced for the aborted access.
  - RAM contents are not cleared.

Decomposition:
- Package cpu_bus_pkg:
  - region_t enum: REG_RAM, REG_PPU, REG_UNMAP, REG_CART.
  - state_t enum: IDLE, RAM_ACC, DEV_WAIT, UNMAP, DONE.
  - Address boundary constants.
  - DEV_SEL_NONE/PPU/CART encodings.
- Sub-module wram_2k: single-port synchronous RAM, 2**RAM_ADDR_W × 8, write-enable, registered read, no reset.

Test Plan:
- Mirror: write $0005 = 8'h5A, then read $1805 → ready 2 cycles after access_EN, data_OUT = 8'h5A, dev_req_OUT never asserted.
- PPU forward: read $3FFA with device acking on the 3rd req cycle with dev_rdata 8'h80 → dev_sel = 1, dev_addr = $2002, dev_rw = 1, ready the cycle after ack, data_OUT = 8'h80.
- Open bus: write $6000 = 8'hC3 (cart acks), then read $4016 → ready after 2 cycles, data_OUT = 8'hC3, timeout_OUT = 0.
- Timeout: read $8000 with no ack, latch = 8'h11 → req held 15 cycles, ready and timeout_OUT pulse together, data_OUT = 8'h11; a later ack is ignored.
- Reset mid-op: reset for 1 cycle during DEV_WAIT → next cycle state IDLE, dev_req = 0, data_OUT = 8'h00, no ready pulse; RAM $0005 still reads 8'h5A.
- Busy reject: access_EN pulsed again during DEV_WAIT with address $0000 → ignored, exactly one ready pulse, dev_addr unchanged.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types and address map for the CPU-side bus responder.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_PPU,
    REG_UNMAP,
    REG_CART
  } region_t;

  typedef enum logic [2:0] {
    IDLE,
    RAM_ACC,
    DEV_WAIT,
    UNMAP,
    DONE
  } state_t;

  localparam logic [15:0] PPU_BASE  = 16'h2000;
  localparam logic [15:0] IO_BASE   = 16'h4000;
  localparam logic [15:0] CART_BASE = 16'h4020;

  localparam logic [1:0] DEV_SEL_NONE = 2'd0;
  localparam logic [1:0] DEV_SEL_PPU  = 2'd1;
  localparam logic [1:0] DEV_SEL_CART = 2'd2;

  function automatic region_t decode_region(input logic [15:0] addr);
    if (addr < PPU_BASE) begin
      return REG_RAM;
    end else if (addr < IO_BASE) begin
      return REG_PPU;
    end else if (addr < CART_BASE) begin
      return REG_UNMAP;
    end else begin
      return REG_CART;
    end
  endfunction

endpackage

// File: rtl/wram_2k.sv
// Single-port work RAM with registered read; contents survive reset.
module wram_2k #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  localparam int unsigned Words = 1 << ADDR_W;

  logic [7:0] mem [Words];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// Device-side responder for the 6502 bus: local work RAM, forwarded PPU/cart
// accesses with a req/ack timeout, and an open-bus data latch.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W  = 11,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic        phi2,
  input  logic        reset,
  input  logic        access_EN,
  input  logic        rw_IN,
  input  logic [15:0] address_IN,
  input  logic [7:0]  data_IN,
  output logic [7:0]  data_OUT,
  output logic        ready_OUT,
  output logic        busy_OUT,
  output logic        timeout_OUT,
  output logic [1:0]  dev_sel_OUT,
  output logic        dev_req_OUT,
  output logic [15:0] dev_addr_OUT,
  output logic        dev_rw_OUT,
  output logic [7:0]  dev_wdata_OUT,
  input  logic [7:0]  dev_rdata_IN,
  input  logic        dev_ack_IN
);

  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic        rw_q, rw_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic [7:0]  obus_q, obus_d;

  logic                  ram_we;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic [7:0]            ram_rdata;

  // The RAM is addressed straight from the CPU bus while idle so its
  // registered output is ready in RAM_ACC and the latch holds it in DONE.
  assign ram_we   = (state_q == RAM_ACC) && !rw_q;
  assign ram_addr = (state_q == IDLE) ? address_IN[RAM_ADDR_W-1:0] : addr_q[RAM_ADDR_W-1:0];

  wram_2k #(
    .ADDR_W (RAM_ADDR_W)
  ) u_wram (
    .clk_i   (phi2),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge phi2) begin
    if (reset) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      wdata_q <= 8'h00;
      addr_q  <= 16'h0000;
      sel_q   <= DEV_SEL_NONE;
      cnt_q   <= 8'h00;
      abort_q <= 1'b0;
      obus_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      obus_q  <= obus_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    obus_d  = obus_q;

    unique case (state_q)
      IDLE: begin
        if (access_EN) begin
          rw_d    = rw_IN;
          wdata_d = data_IN;
          cnt_d   = 8'h00;
          abort_d = 1'b0;
          addr_d  = address_IN;
          unique case (decode_region(address_IN))
            REG_RAM: begin
              state_d = RAM_ACC;
              sel_d   = DEV_SEL_NONE;
            end
            REG_PPU: begin
              state_d = DEV_WAIT;
              sel_d   = DEV_SEL_PPU;
              addr_d  = {13'h0400, address_IN[2:0]};
            end
            REG_UNMAP: begin
              state_d = UNMAP;
              sel_d   = DEV_SEL_NONE;
            end
            REG_CART: begin
              state_d = DEV_WAIT;
              sel_d   = DEV_SEL_CART;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      RAM_ACC: begin
        state_d = DONE;
        obus_d  = rw_q ? ram_rdata : wdata_q;
      end
      DEV_WAIT: begin
        // Ack is checked first so it wins over a timeout in the same cycle.
        if (dev_ack_IN) begin
          state_d = DONE;
          obus_d  = rw_q ? dev_rdata_IN : wdata_q;
        end else if (cnt_q == TmoLast) begin
          state_d = DONE;
          abort_d = 1'b1;
          if (!rw_q) begin
            obus_d = wdata_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      UNMAP: begin
        state_d = DONE;
        if (!rw_q) begin
          obus_d = wdata_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign data_OUT      = obus_q;
  assign ready_OUT     = (state_q == DONE);
  assign busy_OUT      = (state_q != IDLE);
  assign timeout_OUT   = (state_q == DONE) && abort_q;
  assign dev_req_OUT   = (state_q == DEV_WAIT);
  assign dev_sel_OUT   = (state_q == DEV_WAIT) ? sel_q : DEV_SEL_NONE;
  assign dev_addr_OUT  = addr_q;
  assign dev_rw_OUT    = rw_q;
  assign dev_wdata_OUT = wdata_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed self-checking bench for cpu_bus_responder.
module tb_cpu_bus_responder;

  logic        phi2 = 1'b0;
  logic        reset = 1'b1;
  logic        access_EN = 1'b0;
  logic        rw_IN = 1'b0;
  logic [15:0] address_IN = 16'h0000;
  logic [7:0]  data_IN = 8'h00;
  logic [7:0]  data_OUT;
  logic        ready_OUT;
  logic        busy_OUT;
  logic        timeout_OUT;
  logic [1:0]  dev_sel_OUT;
  logic        dev_req_OUT;
  logic [15:0] dev_addr_OUT;
  logic        dev_rw_OUT;
  logic [7:0]  dev_wdata_OUT;
  logic [7:0]  dev_rdata_IN = 8'h00;
  logic        dev_ack_IN = 1'b0;

  int total = 0;
  int bad = 0;
  int ready_cnt = 0;
  int req_cnt = 0;

  cpu_bus_responder #(
    .RAM_ADDR_W  (11),
    .TIMEOUT_CYC (15)
  ) dut (
    .phi2          (phi2),
    .reset         (reset),
    .access_EN     (access_EN),
    .rw_IN         (rw_IN),
    .address_IN    (address_IN),
    .data_IN       (data_IN),
    .data_OUT      (data_OUT),
    .ready_OUT     (ready_OUT),
    .busy_OUT      (busy_OUT),
    .timeout_OUT   (timeout_OUT),
    .dev_sel_OUT   (dev_sel_OUT),
    .dev_req_OUT   (dev_req_OUT),
    .dev_addr_OUT  (dev_addr_OUT),
    .dev_rw_OUT    (dev_rw_OUT),
    .dev_wdata_OUT (dev_wdata_OUT),
    .dev_rdata_IN  (dev_rdata_IN),
    .dev_ack_IN    (dev_ack_IN)
  );

  always #5 phi2 = ~phi2;

  always @(negedge phi2) begin
    if (ready_OUT) ready_cnt++;
    if (dev_req_OUT) req_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge phi2);
    #1;
  endtask

  // Presents one access for the sampling edge; returns in the first busy cycle.
  task automatic start(input logic rw, input logic [15:0] addr, input logic [7:0] wd);
    access_EN  = 1'b1;
    rw_IN      = rw;
    address_IN = addr;
    data_IN    = wd;
    tick();
    access_EN  = 1'b0;
  endtask

  initial begin
    int n;
    int r0;
    int q0;

    // Reset
    tick();
    tick();
    reset = 1'b0;
    check("rst_data", 16'(data_OUT), 16'h00);
    check("rst_ready", 16'(ready_OUT), 16'h0);
    check("rst_busy", 16'(busy_OUT), 16'h0);
    check("rst_tmo", 16'(timeout_OUT), 16'h0);
    check("rst_sel", 16'(dev_sel_OUT), 16'h0);
    check("rst_req", 16'(dev_req_OUT), 16'h0);
    check("rst_addr", dev_addr_OUT, 16'h0000);

    // Mirror: write $0005, read back through $1805
    q0 = req_cnt;
    start(1'b0, 16'h0005, 8'h5A);
    check("mir_w_busy", 16'(busy_OUT), 16'h1);
    check("mir_w_rdy0", 16'(ready_OUT), 16'h0);
    tick();
    check("mir_w_rdy", 16'(ready_OUT), 16'h1);
    tick();
    start(1'b1, 16'h1805, 8'h00);
    check("mir_r_rdy0", 16'(ready_OUT), 16'h0);
    tick();
    check("mir_r_rdy", 16'(ready_OUT), 16'h1);
    check("mir_r_data", 16'(data_OUT), 16'h5A);
    tick();
    check("mir_noreq", 16'(req_cnt - q0), 16'h0);
    check("mir_idle", 16'(busy_OUT), 16'h0);

    // PPU forward: $3FFA read, ack on 3rd request cycle
    start(1'b1, 16'h3FFA, 8'h00);
    check("ppu_req", 16'(dev_req_OUT), 16'h1);
    check("ppu_sel", 16'(dev_sel_OUT), 16'h1);
    check("ppu_addr", dev_addr_OUT, 16'h2002);
    check("ppu_rw", 16'(dev_rw_OUT), 16'h1);
    tick();
    tick();
    check("ppu_rdy0", 16'(ready_OUT), 16'h0);
    dev_ack_IN   = 1'b1;
    dev_rdata_IN = 8'h80;
    tick();
    dev_ack_IN   = 1'b0;
    check("ppu_rdy", 16'(ready_OUT), 16'h1);
    check("ppu_data", 16'(data_OUT), 16'h80);
    check("ppu_req_drop", 16'(dev_req_OUT), 16'h0);
    check("ppu_tmo", 16'(timeout_OUT), 16'h0);
    tick();

    // Open bus: cart write $6000 = C3, then unmapped read $4016
    start(1'b0, 16'h6000, 8'hC3);
    check("cart_sel", 16'(dev_sel_OUT), 16'h2);
    check("cart_addr", dev_addr_OUT, 16'h6000);
    check("cart_rw", 16'(dev_rw_OUT), 16'h0);
    check("cart_wdata", 16'(dev_wdata_OUT), 16'hC3);
    dev_ack_IN = 1'b1;
    tick();
    dev_ack_IN = 1'b0;
    check("cart_w_rdy", 16'(ready_OUT), 16'h1);
    tick();
    q0 = req_cnt;
    start(1'b1, 16'h4016, 8'h00);
    check("ob_rdy0", 16'(ready_OUT), 16'h0);
    tick();
    check("ob_rdy", 16'(ready_OUT), 16'h1);
    check("ob_data", 16'(data_OUT), 16'hC3);
    check("ob_tmo", 16'(timeout_OUT), 16'h0);
    tick();
    check("ob_noreq", 16'(req_cnt - q0), 16'h0);

    // Timeout: latch set to 11 by a RAM write, then unanswered $8000 read
    start(1'b0, 16'h0000, 8'h11);
    tick();
    tick();
    start(1'b1, 16'h8000, 8'h00);
    n = 0;
    while (dev_req_OUT && n < 40) begin
      n++;
      tick();
    end
    check("tmo_req_cycles", 16'(n), 16'd15);
    check("tmo_rdy", 16'(ready_OUT), 16'h1);
    check("tmo_pulse", 16'(timeout_OUT), 16'h1);
    check("tmo_data", 16'(data_OUT), 16'h11);
    tick();
    check("tmo_pulse_end", 16'(timeout_OUT), 16'h0);
    dev_ack_IN   = 1'b1;
    dev_rdata_IN = 8'hEE;
    tick();
    dev_ack_IN   = 1'b0;
    check("late_ack_rdy", 16'(ready_OUT), 16'h0);
    check("late_ack_busy", 16'(busy_OUT), 16'h0);
    check("late_ack_data", 16'(data_OUT), 16'h11);

    // Ack on the final timeout cycle wins
    start(1'b1, 16'h8000, 8'h00);
    for (int i = 0; i < 14; i++) tick();
    check("tie_req", 16'(dev_req_OUT), 16'h1);
    dev_ack_IN   = 1'b1;
    dev_rdata_IN = 8'h9E;
    tick();
    dev_ack_IN   = 1'b0;
    check("tie_rdy", 16'(ready_OUT), 16'h1);
    check("tie_tmo", 16'(timeout_OUT), 16'h0);
    check("tie_data", 16'(data_OUT), 16'h9E);
    tick();

    // Reset during DEV_WAIT
    start(1'b1, 16'h8000, 8'h00);
    tick();
    r0 = ready_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_req", 16'(dev_req_OUT), 16'h0);
    check("mid_rst_busy", 16'(busy_OUT), 16'h0);
    check("mid_rst_data", 16'(data_OUT), 16'h00);
    tick();
    tick();
    check("mid_rst_nordy", 16'(ready_cnt - r0), 16'h0);
    start(1'b1, 16'h0005, 8'h00);
    tick();
    check("ram_kept", 16'(data_OUT), 16'h5A);
    tick();

    // Busy reject: second strobe to $0000 during a cart read
    start(1'b1, 16'h6001, 8'h00);
    r0 = ready_cnt;
    start(1'b0, 16'h0000, 8'h77);
    check("rej_addr", dev_addr_OUT, 16'h6001);
    check("rej_req", 16'(dev_req_OUT), 16'h1);
    dev_ack_IN   = 1'b1;
    dev_rdata_IN = 8'h3C;
    tick();
    dev_ack_IN   = 1'b0;
    check("rej_data", 16'(data_OUT), 16'h3C);
    tick();
    tick();
    tick();
    check("rej_one_rdy", 16'(ready_cnt - r0), 16'h1);
    start(1'b1, 16'h0000, 8'h00);
    tick();
    check("rej_ram_intact", 16'(data_OUT), 16'h11);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
